// File: rtl/multicycle_control_if.sv
// multicycle_control_if: bundles the opcode/handshake inputs and the control
// outputs that run between the multicycle controller and the shared datapath.
// When ILLEGAL_TRAP_EN is defined, the bundle also carries illegal_op.
interface multicycle_control_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       pcwrite;
  logic       pcwritecond;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       memtoreg;
  logic       irwrite;
  logic       regdst;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic [1:0] pcsource;
  logic [3:0] state;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  // Controller side: consumes the opcode and the memory handshake, drives the controls.
  modport master (
`ifdef ILLEGAL_TRAP_EN
    output illegal_op,
`endif
    input  op, mem_ready,
    output pcwrite, pcwritecond, iord, memread, memwrite, memtoreg,
    output irwrite, regdst, regwrite, alusrca, alusrcb, aluop, pcsource, state
  );

  // Datapath side: supplies the opcode and the memory handshake, obeys the controls.
  modport slave (
`ifdef ILLEGAL_TRAP_EN
    input  illegal_op,
`endif
    output op, mem_ready,
    input  pcwrite, pcwritecond, iord, memread, memwrite, memtoreg,
    input  irwrite, regdst, regwrite, alusrca, alusrcb, aluop, pcsource, state
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM that sequences the shared multicycle datapath
// (one ALU, one memory port). It decodes the IR opcode, drives ALUOp into
// alucont along with the mux selects and write enables, and waits on mem_ready
// in the memory states.
// Optional feature macro: ILLEGAL_TRAP_EN. When it is defined, an unknown opcode
// parks the FSM in TRAP with illegal_op=1 until reset. When it is undefined, an
// unknown opcode acts as a NOP and the FSM returns to FETCH.
module multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_J     = 6'h02
) (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_RTEX   = 4'd7,
    S_RTWB   = 4'd8,
    S_BEQ    = 4'd9,
    S_JUMP   = 4'd10,
    S_TRAP   = 4'd11
  } state_t;

  // Registered control word. 'fetch' marks the FETCH state. The IR load and the
  // PC increment are gated by mem_ready outside the register, so they take
  // effect only on the cycle in which the instruction word actually arrives.
  typedef struct packed {
    logic       fetch;
    logic       pcwrite_u;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = 16'd0;

  // Moore output table. Anything not set here stays 0. IDLE, TRAP and the
  // unused encodings all produce the all-zero word.
  function automatic ctrl_t f_decode(input state_t st);
    ctrl_t c;
    c = CTRL_NONE;
    case (st)
      S_FETCH: begin
        c.fetch   = 1'b1;
        c.memread = 1'b1;
        c.alusrcb = 2'b01;
      end
      S_DECODE: begin
        c.alusrcb = 2'b11;
      end
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_MEMRD: begin
        c.memread = 1'b1;
        c.iord    = 1'b1;
      end
      S_MEMWB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
        c.regdst   = 1'b0;
      end
      S_MEMWR: begin
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
      end
      S_RTEX: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b10;
      end
      S_RTWB: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
      end
      S_BEQ: begin
        c.alusrca     = 1'b1;
        c.aluop       = 2'b01;
        c.pcwritecond = 1'b1;
        c.pcsource    = 2'b01;
      end
      S_JUMP: begin
        c.pcwrite_u = 1'b1;
        c.pcsource  = 2'b10;
      end
      default: begin
        c = CTRL_NONE;
      end
    endcase
    return c;
  endfunction

  state_t r_state;
  state_t w_next_state;
  ctrl_t  r_ctrl;
  logic   w_fetch_done;
`ifdef ILLEGAL_TRAP_EN
  logic   r_illegal_op;
`endif

  // Next-state logic: the opcode steers DECODE and MEMADR, and mem_ready holds the memory states.
  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_IDLE: begin
        w_next_state = S_FETCH;
      end
      S_FETCH: begin
        if (bus.mem_ready) begin
          w_next_state = S_DECODE;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_DECODE: begin
        if ((bus.op == OP_LW) || (bus.op == OP_SW)) begin
          w_next_state = S_MEMADR;
        end else if (bus.op == OP_RTYPE) begin
          w_next_state = S_RTEX;
        end else if (bus.op == OP_BEQ) begin
          w_next_state = S_BEQ;
        end else if (bus.op == OP_J) begin
          w_next_state = S_JUMP;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          w_next_state = S_TRAP;
`else
          w_next_state = S_FETCH;
`endif
        end
      end
      S_MEMADR: begin
        if (bus.op == OP_LW) begin
          w_next_state = S_MEMRD;
        end else begin
          w_next_state = S_MEMWR;
        end
      end
      S_MEMRD: begin
        if (bus.mem_ready) begin
          w_next_state = S_MEMWB;
        end else begin
          w_next_state = S_MEMRD;
        end
      end
      S_MEMWB: begin
        w_next_state = S_FETCH;
      end
      S_MEMWR: begin
        if (bus.mem_ready) begin
          w_next_state = S_FETCH;
        end else begin
          w_next_state = S_MEMWR;
        end
      end
      S_RTEX: begin
        w_next_state = S_RTWB;
      end
      S_RTWB: begin
        w_next_state = S_FETCH;
      end
      S_BEQ: begin
        w_next_state = S_FETCH;
      end
      S_JUMP: begin
        w_next_state = S_FETCH;
      end
      S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        w_next_state = S_TRAP;
`else
        w_next_state = S_FETCH;
`endif
      end
      default: begin
        w_next_state = S_FETCH;
      end
    endcase
  end

  // State register plus registered Moore outputs. The outputs are decoded from
  // the next state, so they line up with the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_ctrl       <= CTRL_NONE;
`ifdef ILLEGAL_TRAP_EN
      r_illegal_op <= 1'b0;
`endif
    end else begin
      r_state      <= w_next_state;
      r_ctrl       <= f_decode(w_next_state);
`ifdef ILLEGAL_TRAP_EN
      r_illegal_op <= (w_next_state == S_TRAP);
`endif
    end
  end

  // In FETCH, the IR load and the PC+4 write happen only once memory delivers the word.
  assign w_fetch_done    = r_ctrl.fetch & bus.mem_ready;

  assign bus.pcwrite     = r_ctrl.pcwrite_u | w_fetch_done;
  assign bus.irwrite     = w_fetch_done;
  assign bus.pcwritecond = r_ctrl.pcwritecond;
  assign bus.iord        = r_ctrl.iord;
  assign bus.memread     = r_ctrl.memread;
  assign bus.memwrite    = r_ctrl.memwrite;
  assign bus.memtoreg    = r_ctrl.memtoreg;
  assign bus.regdst      = r_ctrl.regdst;
  assign bus.regwrite    = r_ctrl.regwrite;
  assign bus.alusrca     = r_ctrl.alusrca;
  assign bus.alusrcb     = r_ctrl.alusrcb;
  assign bus.aluop       = r_ctrl.aluop;
  assign bus.pcsource    = r_ctrl.pcsource;
  assign bus.state       = r_state;
`ifdef ILLEGAL_TRAP_EN
  assign bus.illegal_op  = r_illegal_op;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: self-checking bench for multicycle_control. A
// reference model builds each instruction as a list of expected states from the
// instruction class and the number of memory wait cycles. The control word for
// each state comes from the behavioural output table. Both builds
// (ILLEGAL_TRAP_EN defined or not) are handled.
module tb_multicycle_control;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       irwrite;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
  } ctrl_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control word for a state number. In FETCH, the IR load and the PC
  // write follow mem_ready.
  function automatic ctrl_t exp_ctrl(input logic [3:0] st, input logic mr);
    ctrl_t c;
    c = '0;
    case (st)
      4'd1:  begin c.memread = 1'b1; c.alusrcb = 2'b01; c.irwrite = mr; c.pcwrite = mr; end
      4'd2:  c.alusrcb = 2'b11;
      4'd3:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      4'd4:  begin c.memread = 1'b1; c.iord = 1'b1; end
      4'd5:  begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
      4'd6:  begin c.memwrite = 1'b1; c.iord = 1'b1; end
      4'd7:  begin c.alusrca = 1'b1; c.aluop = 2'b10; end
      4'd8:  begin c.regwrite = 1'b1; c.regdst = 1'b1; end
      4'd9:  begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcwritecond = 1'b1; c.pcsource = 2'b01; end
      4'd10: begin c.pcwrite = 1'b1; c.pcsource = 2'b10; end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic bit is_legal(input logic [5:0] o);
    return (o == OP_RTYPE) || (o == OP_LW) || (o == OP_SW) || (o == OP_BEQ) || (o == OP_J);
  endfunction

  // Compare the state, the control word and (when built in) illegal_op with the model.
  task automatic check(input logic [3:0] st, input logic mr, input string tag);
    ctrl_t obs;
    ctrl_t exp;
    obs = {bus.pcwrite, bus.pcwritecond, bus.iord, bus.memread, bus.memwrite,
           bus.memtoreg, bus.irwrite, bus.regdst, bus.regwrite, bus.alusrca,
           bus.alusrcb, bus.aluop, bus.pcsource};
    exp = exp_ctrl(st, mr);
    checks++;
    assert (bus.state === st) else begin
      errors++;
      $error("FAIL %s.state observed %0d expected %0d", tag, bus.state, st);
    end
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.ctrl observed %h expected %h (state %0d)", tag, obs, exp, st);
    end
`ifdef ILLEGAL_TRAP_EN
    checks++;
    assert (bus.illegal_op === (st == 4'd11)) else begin
      errors++;
      $error("FAIL %s.illegal_op observed %b expected %b", tag, bus.illegal_op, (st == 4'd11));
    end
`endif
  endtask

  // One clock cycle: drive mem_ready, check outputs mid-cycle, then advance.
  task automatic run_cycle(input logic [3:0] st, input logic mr, input string tag);
    bus.mem_ready = mr;
    #1;
    check(st, mr, tag);
    @(posedge clk);
    #1;
  endtask

  // Hold reset for a cycle while checking IDLE, then release it so the next edge enters FETCH.
  task automatic do_reset();
    reset = 1'b1;
    bus.mem_ready = 1'($urandom);
    #1;
    check(4'd0, bus.mem_ready, "reset_async");
    @(posedge clk);
    #1;
    check(4'd0, bus.mem_ready, "reset_hold");
    reset = 1'b0;
    #1;
    check(4'd0, bus.mem_ready, "idle_release");
    @(posedge clk);
    #1;
  endtask

  // Model of one instruction: fetch (fw waits), decode, then the path for the opcode class.
  task automatic run_instr(input logic [5:0] opc, input int fw, input int mw);
    for (int i = 0; i < fw; i++) begin
      bus.op = 6'($urandom);
      run_cycle(4'd1, 1'b0, "fetch_wait");
    end
    bus.op = 6'($urandom);
    run_cycle(4'd1, 1'b1, "fetch");
    bus.op = opc;
    run_cycle(4'd2, 1'($urandom), "decode");
    if (opc == OP_LW) begin
      run_cycle(4'd3, 1'($urandom), "lw_memadr");
      for (int i = 0; i < mw; i++) run_cycle(4'd4, 1'b0, "lw_memrd_wait");
      run_cycle(4'd4, 1'b1, "lw_memrd");
      run_cycle(4'd5, 1'($urandom), "lw_memwb");
    end else if (opc == OP_SW) begin
      run_cycle(4'd3, 1'($urandom), "sw_memadr");
      for (int i = 0; i < mw; i++) run_cycle(4'd6, 1'b0, "sw_memwr_wait");
      run_cycle(4'd6, 1'b1, "sw_memwr");
    end else if (opc == OP_RTYPE) begin
      run_cycle(4'd7, 1'($urandom), "rtex");
      run_cycle(4'd8, 1'($urandom), "rtwb");
    end else if (opc == OP_BEQ) begin
      run_cycle(4'd9, 1'($urandom), "beq");
    end else if (opc == OP_J) begin
      run_cycle(4'd10, 1'($urandom), "jump");
    end else begin
`ifdef ILLEGAL_TRAP_EN
      for (int i = 0; i < 3; i++) run_cycle(4'd11, 1'($urandom), "trap");
      do_reset();
`endif
    end
  endtask

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Directed sequence followed by randomized instructions.
  initial begin
    logic [5:0] o;
    int         k;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.op = 6'h00;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Directed: the spec's sequences, including mem waits in MEMWR.
    run_instr(OP_LW, 0, 0);
    run_instr(OP_RTYPE, 0, 0);
    run_instr(OP_SW, 0, 3);
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_J, 0, 0);
    run_instr(OP_LW, 2, 2);
    run_instr(6'h3F, 0, 0);
    run_instr(OP_J, 1, 0);

    // Directed: reset asserted mid-cycle while MEMRD waits aborts to IDLE at once.
    bus.op = 6'($urandom);
    run_cycle(4'd1, 1'b1, "ab_fetch");
    bus.op = OP_LW;
    run_cycle(4'd2, 1'b1, "ab_decode");
    run_cycle(4'd3, 1'b0, "ab_memadr");
    bus.mem_ready = 1'b0;
    #1;
    check(4'd4, 1'b0, "ab_memrd");
    reset = 1'b1;
    #1;
    check(4'd0, 1'b0, "ab_reset_immediate");
    @(posedge clk);
    #1;
    do_reset();

    // Randomized instruction stream.
    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 5);
      case (k)
        0: o = OP_RTYPE;
        1: o = OP_LW;
        2: o = OP_SW;
        3: o = OP_BEQ;
        4: o = OP_J;
        default: begin
          o = 6'($urandom);
          while (is_legal(o)) o = 6'($urandom);
        end
      endcase
      run_instr(o, ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3),
                ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
